// File: rtl/clock_pkg.sv
// Mode encoding shared by the clock-setting controller and anything that decodes its mode output.
package clock_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_e;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      RUN:     next_mode = SET_HR;
      SET_HR:  next_mode = SET_MIN;
      default: next_mode = RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: two-flop synchroniser, 2-sample filter clocked by the sample tick,
// and a one-clk pulse on each debounced rising edge.
module btn_debounce (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press
);

  logic       sync1_q, sync2_q;
  logic [1:0] hist_q, hist_d;
  logic       level_q, level_d;
  logic       level_prev_q;

  // Level only changes once both history samples agree; mixed samples hold it.
  always_comb begin
    hist_d  = hist_q;
    level_d = level_q;
    if (tick) begin
      hist_d = {hist_q[0], sync2_q};
      if (hist_d == 2'b11)      level_d = 1'b1;
      else if (hist_d == 2'b00) level_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= 2'b00;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      hist_q       <= hist_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign level = level_q;
  assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounced mode/up buttons drive a RUN/SET_HR/SET_MIN sequence
// with increment pulses, auto-repeat on a held up button, and a blink for the field being set.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int SAMPLE_DIV   = 1000000,
  parameter int REPEAT_TICKS = 50,
  parameter int BLINK_TICKS  = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_up,
  output logic [MODE_W-1:0] mode,
  output logic              run_en,
  output logic              inc_hr,
  output logic              inc_min,
  output logic              clr_sec,
  output logic              blink
);

  localparam int DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HOLD_W  = $clog2(REPEAT_TICKS + 1);
  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(REPEAT_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick, tick_q;
  mode_e              mode_q, mode_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [BLINK_W-1:0] bcnt_q, bcnt_d;
  logic               blink_q, blink_d;
  logic               run_en_q, inc_hr_q, inc_min_q, clr_sec_q;
  logic               up_fire;
  logic               mode_press, up_press, up_level, mode_level_unused;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  btn_debounce u_mode_btn (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .raw   (btn_mode),
    .level (mode_level_unused),
    .press (mode_press)
  );

  btn_debounce u_up_btn (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .raw   (btn_up),
    .level (up_level),
    .press (up_press)
  );

  // tick_q lets the repeat counter see the debounced level already updated by that tick.
  always_comb begin
    mode_d  = mode_press ? next_mode(mode_q) : mode_q;
    hold_d  = hold_q;
    up_fire = 1'b0;
    if (mode_press || mode_q == RUN || !up_level) begin
      hold_d = '0;
    end else if (up_press) begin
      up_fire = 1'b1;
      hold_d  = '0;
    end else if (tick_q) begin
      if (hold_q == HOLD_LAST) begin
        up_fire = 1'b1;
        hold_d  = '0;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_comb begin
    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if (mode_press) begin
      blink_d = (mode_d != RUN);
      bcnt_d  = '0;
    end else if (mode_q == RUN) begin
      blink_d = 1'b0;
      bcnt_d  = '0;
    end else if (tick) begin
      if (bcnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
        bcnt_d  = '0;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      tick_q    <= 1'b0;
      mode_q    <= RUN;
      hold_q    <= '0;
      bcnt_q    <= '0;
      blink_q   <= 1'b0;
      run_en_q  <= 1'b1;
      inc_hr_q  <= 1'b0;
      inc_min_q <= 1'b0;
      clr_sec_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      tick_q    <= tick;
      mode_q    <= mode_d;
      hold_q    <= hold_d;
      bcnt_q    <= bcnt_d;
      blink_q   <= blink_d;
      run_en_q  <= (mode_d == RUN);
      inc_hr_q  <= up_fire && (mode_q == SET_HR);
      inc_min_q <= up_fire && (mode_q == SET_MIN);
      clr_sec_q <= mode_press && (mode_q == SET_MIN);
    end
  end

  assign mode    = mode_q;
  assign run_en  = run_en_q;
  assign inc_hr  = inc_hr_q;
  assign inc_min = inc_min_q;
  assign clr_sec = clr_sec_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with SAMPLE_DIV=4, REPEAT_TICKS=3, BLINK_TICKS=2.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btnMode, btnUp;
  logic [1:0] mode;
  logic       runEn, incHr, incMin, clrSec, blink;

  int compareCount = 0;
  int mismatchCount = 0;

  int cyc = 0;
  int hrTotal = 0, minTotal = 0, clrTotal = 0, clrGood = 0, bothHigh = 0;
  int hrLog[$];
  int minLog[$];
  logic [1:0] prevMode = 2'b00;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .SAMPLE_DIV  (4),
    .REPEAT_TICKS(3),
    .BLINK_TICKS (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_mode(btnMode),
    .btn_up  (btnUp),
    .mode    (mode),
    .run_en  (runEn),
    .inc_hr  (incHr),
    .inc_min (incMin),
    .clr_sec (clrSec),
    .blink   (blink)
  );

  // cyc mod 4 tracks the sample divider, which restarts at zero with reset.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (incHr) begin
      hrTotal++;
      hrLog.push_back(cyc);
    end
    if (incMin) begin
      minTotal++;
      minLog.push_back(cyc);
    end
    if (clrSec) begin
      clrTotal++;
      if (mode == 2'b00 && prevMode == 2'b10) clrGood++;
    end
    if (incHr && incMin) bothHigh++;
    prevMode = mode;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic u, input int cycles);
    btnMode = m;
    btnUp   = u;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pressMode();
    applyStimulus(1'b1, 1'b0, 16);
    applyStimulus(1'b0, 1'b0, 16);
  endtask

  // Places the next drive on the negedge whose value is the one the tick samples.
  task automatic alignPhase();
    for (int i = 0; i < 8 && (cyc % 4) != 1; i++) @(negedge clk);
  endtask

  task automatic enterSetAndCheckBlink();
    logic [1:0] startMode;
    int n;
    startMode = mode;
    n = 0;
    btnMode = 1'b1;
    while (mode == startMode && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("enterSetHr", mode, 1);
    checkOutput("blinkOnEntry", blink, 1);
    repeat (6) @(negedge clk);
    checkOutput("blinkStillOn", blink, 1);
    @(negedge clk);
    checkOutput("blinkToggled", blink, 0);
    applyStimulus(1'b0, 1'b0, 24);
  endtask

  initial begin
    int hb, mb, cb, idx, c0, lat;

    btnMode = 1'b0;
    btnUp   = 1'b0;
    reset   = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("resetMode", mode, 0);
    checkOutput("resetRunEn", runEn, 1);
    checkOutput("resetIncHr", incHr, 0);
    checkOutput("resetIncMin", incMin, 0);
    checkOutput("resetClrSec", clrSec, 0);
    checkOutput("resetBlink", blink, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 4);

    // Mode cycling
    enterSetAndCheckBlink();
    checkOutput("runEnSetHr", runEn, 0);
    pressMode();
    checkOutput("modeSetMin", mode, 2);
    checkOutput("runEnSetMin", runEn, 0);
    checkOutput("noClrYet", clrTotal, 0);
    pressMode();
    checkOutput("modeBackRun", mode, 0);
    checkOutput("runEnRun", runEn, 1);
    checkOutput("clrSecOnce", clrTotal, 1);
    checkOutput("clrSecOnReturn", clrGood, 1);
    checkOutput("blinkOffRun", blink, 0);

    // Bounce on up in SET_HR, then a clean 2-tick hold
    pressMode();
    checkOutput("bounceModeHr", mode, 1);
    hb = hrTotal; mb = minTotal; idx = hrLog.size();
    alignPhase();
    c0 = cyc;
    for (int k = 0; k < 12; k++) begin
      btnUp = (k % 2 == 1);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b1, 8);
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("bounceIncHrCount", hrTotal - hb, 1);
    checkOutput("bounceIncMinCount", minTotal - mb, 0);
    lat = (hrLog.size() > idx) ? hrLog[idx] - c0 : -1;
    checkOutput("bounceIncHrTime", lat, 20);

    // Samples alternating 1/0 never settle
    hb = hrTotal;
    for (int s = 0; s < 8; s++) applyStimulus(1'b0, (s % 2 == 0), 4);
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("glitchIgnored", hrTotal - hb, 0);

    // Auto-repeat in SET_MIN: nine samples high
    pressMode();
    checkOutput("repeatModeMin", mode, 2);
    hb = hrTotal; mb = minTotal; idx = minLog.size();
    alignPhase();
    c0 = cyc;
    applyStimulus(1'b0, 1'b1, 36);
    applyStimulus(1'b0, 1'b0, 24);
    checkOutput("repeatIncMinCount", minTotal - mb, 3);
    checkOutput("repeatIncHrCount", hrTotal - hb, 0);
    lat = (minLog.size() > idx) ? minLog[idx] - c0 : -1;
    checkOutput("repeatPressTime", lat, 8);
    lat = (minLog.size() > idx + 1) ? minLog[idx + 1] - c0 : -1;
    checkOutput("repeatFirstTime", lat, 20);
    lat = (minLog.size() > idx + 2) ? minLog[idx + 2] - c0 : -1;
    checkOutput("repeatSecondTime", lat, 32);

    // Collision: mode and up debounce on the same tick
    pressMode();
    pressMode();
    checkOutput("collisionStartHr", mode, 1);
    hb = hrTotal; mb = minTotal;
    applyStimulus(1'b1, 1'b1, 8);
    applyStimulus(1'b0, 1'b0, 24);
    checkOutput("collisionMode", mode, 2);
    checkOutput("collisionNoIncHr", hrTotal - hb, 0);
    checkOutput("collisionNoIncMin", minTotal - mb, 0);

    // Up presses in RUN are ignored, including a long hold
    pressMode();
    checkOutput("ignoreModeRun", mode, 0);
    hb = hrTotal; mb = minTotal;
    applyStimulus(1'b0, 1'b1, 48);
    applyStimulus(1'b0, 1'b0, 24);
    checkOutput("ignoreIncHr", hrTotal - hb, 0);
    checkOutput("ignoreIncMin", minTotal - mb, 0);
    checkOutput("ignoreRunEn", runEn, 1);

    // Reset in SET_MIN abandons the set state silently
    pressMode();
    pressMode();
    checkOutput("preResetModeMin", mode, 2);
    cb = clrTotal;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("resetModeNextClk", mode, 0);
    checkOutput("resetRunEnNextClk", runEn, 1);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8);
    checkOutput("resetNoClrSec", clrTotal - cb, 0);

    // Mode button held through reset becomes a fresh press
    btnMode = 1'b1;
    reset   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("heldAfterResetStillRun", mode, 0);
    applyStimulus(1'b1, 1'b0, 16);
    checkOutput("heldThroughResetPress", mode, 1);
    applyStimulus(1'b0, 1'b0, 24);

    checkOutput("neverBothInc", bothHigh, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
